// File: rtl/pulse_generator_pkg.sv
// Shared types and helpers for the trigger-to-gate pulse generator and its
// statistics counters.
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    PG_IDLE    = 2'd0,
    PG_ACTIVE  = 2'd1,
    PG_HOLDOFF = 2'd2
  } pg_state_t;

  // All-ones value of a w-bit counter, used as the saturation ceiling.
  function automatic logic [63:0] sat_max(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over
// increment so a clear is never lost to a simultaneous event.
module sat_counter
  import pulse_generator_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = W'(sat_max(W));

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_COUNT)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pulse_generator.sv
// Stretches single-cycle trigger strobes into fixed-width gate pulses followed
// by a dead time; triggers arriving while busy are rejected and counted.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DROP_W    = 16,
  parameter int RETRIGGER = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  pulse_len,
  input  logic [CNT_W-1:0]  holdoff_len,
  input  logic              clr_drop,
  output logic              pulse_out,
  output logic              busy,
  output logic              dropped,
  output logic [DROP_W-1:0] drop_count
);

  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] hold_lat_q, hold_lat_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;
  logic             len_ok;
  logic             reject;

  assign len_ok = (pulse_len != '0);

  // Configuration is only sampled on acceptance, so a pulse in flight runs
  // on its latched width/hold-off regardless of later port changes.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    hold_d     = hold_q;
    hold_lat_d = hold_lat_q;
    reject     = 1'b0;

    case (state_q)
      PG_IDLE: begin
        if (trigger && len_ok) begin
          state_d    = PG_ACTIVE;
          width_d    = pulse_len;
          hold_lat_d = holdoff_len;
        end
      end

      PG_ACTIVE: begin
        if (trigger && (RETRIGGER != 0) && len_ok) begin
          width_d    = pulse_len;
          hold_lat_d = holdoff_len;
        end else begin
          reject = trigger;
          if (width_q == CNT_W'(1)) begin
            width_d = '0;
            if (hold_lat_q != '0) begin
              state_d = PG_HOLDOFF;
              hold_d  = hold_lat_q;
            end else begin
              state_d = PG_IDLE;
            end
          end else begin
            width_d = width_q - CNT_W'(1);
          end
        end
      end

      PG_HOLDOFF: begin
        reject = trigger;
        if (hold_q == CNT_W'(1)) begin
          state_d = PG_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = PG_IDLE;
      end
    endcase

    pulse_d   = (state_d == PG_ACTIVE);
    busy_d    = (state_d != PG_IDLE);
    dropped_d = reject;
  end

  // Outputs are decoded from the next state into their own flops so that
  // they come straight off registers with no path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PG_IDLE;
      width_q    <= '0;
      hold_q     <= '0;
      hold_lat_q <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      hold_q     <= hold_d;
      hold_lat_q <= hold_lat_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  sat_counter #(
    .W(DROP_W)
  ) u_drop_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (reject),
    .clr   (clr_drop),
    .count (drop_count)
  );

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Drives three pulse_generator variants (plain, retriggerable, 2-bit drop
// counter) with shared stimulus and checks them against a timeline model.
module tb_pulse_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger;
  logic        clr_drop;
  logic [15:0] pulse_len;
  logic [15:0] holdoff_len;

  logic        p0, p1, p2, b0, b1, b2, d0, d1, d2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;

  // Model: each accepted trigger fixes the last pulse cycle and last busy cycle.
  longint pend[3];
  longint bend[3];
  bit     dnx[3];
  int     mcnt[3];
  int     mmax[3]   = '{65535, 65535, 3};
  bit     retrig[3] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    logic trig;
    logic exp_pulse;
    logic exp_busy;
    logic exp_drop;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[26];

  always #5 clk = ~clk;

  pulse_generator #(.CNT_W(16), .DROP_W(16), .RETRIGGER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .pulse_len(pulse_len),
    .holdoff_len(holdoff_len), .clr_drop(clr_drop), .pulse_out(p0),
    .busy(b0), .dropped(d0), .drop_count(cnt0));

  pulse_generator #(.CNT_W(16), .DROP_W(16), .RETRIGGER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .pulse_len(pulse_len),
    .holdoff_len(holdoff_len), .clr_drop(clr_drop), .pulse_out(p1),
    .busy(b1), .dropped(d1), .drop_count(cnt1));

  pulse_generator #(.CNT_W(16), .DROP_W(2), .RETRIGGER(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .pulse_len(pulse_len),
    .holdoff_len(holdoff_len), .clr_drop(clr_drop), .pulse_out(p2),
    .busy(b2), .dropped(d2), .drop_count(cnt2));

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pend[i] = -1;
      bend[i] = -1;
      dnx[i]  = 1'b0;
      mcnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic t, input logic [15:0] l, input logic [15:0] h,
                            input logic c);
    for (int i = 0; i < 3; i++) begin
      dnx[i] = 1'b0;
      if (t) begin
        if (cyc > bend[i]) begin
          if (l != 0) begin
            pend[i] = cyc + l;
            bend[i] = cyc + l + h;
          end
        end else if (retrig[i] && (cyc <= pend[i]) && (l != 0)) begin
          pend[i] = cyc + l;
          bend[i] = cyc + l + h;
        end else begin
          dnx[i] = 1'b1;
          if (mcnt[i] < mmax[i]) mcnt[i]++;
        end
      end
      if (c) mcnt[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic   p, b, d;
      longint cv;
      case (i)
        0:       begin p = p0; b = b0; d = d0; cv = cnt0; end
        1:       begin p = p1; b = b1; d = d1; cv = cnt1; end
        default: begin p = p2; b = b2; d = d2; cv = cnt2; end
      endcase
      check_output($sformatf("dut%0d pulse_out", i), p, cyc <= pend[i]);
      check_output($sformatf("dut%0d busy", i), b, cyc <= bend[i]);
      check_output($sformatf("dut%0d dropped", i), d, dnx[i]);
      check_output($sformatf("dut%0d drop_count", i), cv, mcnt[i]);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive this cycle's inputs.
  task automatic apply_stimulus(input logic t, input logic [15:0] l, input logic [15:0] h,
                                input logic c);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    trigger     = t;
    pulse_len   = l;
    holdoff_len = h;
    clr_drop    = c;
    model_step(t, l, h, c);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 16'd4, 16'd3, 1'b0);
  endtask

  initial begin
    int highs;

    for (int k = 0; k < 26; k++) begin
      tbl[k].trig      = (k inside {0, 8, 16, 19, 23});
      tbl[k].exp_pulse = (k inside {[1:4], [9:12], [17:20]});
      tbl[k].exp_busy  = (k inside {[1:7], [9:15], [17:23]});
      tbl[k].exp_drop  = (k inside {20, 24});
      tbl[k].exp_cnt   = (k >= 24) ? 2 : ((k >= 20) ? 1 : 0);
    end

    rst_n       = 1'b0;
    trigger     = 1'b0;
    clr_drop    = 1'b0;
    pulse_len   = 16'd4;
    holdoff_len = 16'd3;
    model_reset();

    #3;
    check_output("reset pulse_out", p0, 0);
    check_output("reset busy", b0, 0);
    check_output("reset dropped", d0, 0);
    check_output("reset drop_count", cnt0, 0);
    #19 rst_n = 1'b1;

    // Table: accept at 0, re-accept right after hold-off at 8, then rejects in
    // ACTIVE (19) and in the last hold-off cycle (23).
    for (int k = 0; k < 26; k++) begin
      apply_stimulus(tbl[k].trig, 16'd4, 16'd3, 1'b0);
      check_output($sformatf("table[%0d] pulse_out", k), p0, tbl[k].exp_pulse);
      check_output($sformatf("table[%0d] busy", k), b0, tbl[k].exp_busy);
      check_output($sformatf("table[%0d] dropped", k), d0, tbl[k].exp_drop);
      check_output($sformatf("table[%0d] drop_count", k), cnt0, tbl[k].exp_cnt);
    end
    idle(12);

    for (int k = 0; k < 10; k++) begin
      apply_stimulus(k == 0 || k == 2, 16'd4, 16'd3, 1'b0);
      if (k >= 1) begin
        check_output($sformatf("retrigger k=%0d pulse_out", k), p1, k <= 6);
        check_output($sformatf("retrigger k=%0d dropped", k), d1, 0);
      end
    end
    idle(6);

    apply_stimulus(1'b1, 16'd0, 16'd3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(1'b0, 16'd0, 16'd3, 1'b0);
      check_output("len0 pulse_out", p0, 0);
      check_output("len0 busy", b0, 0);
      check_output("len0 dropped", d0, 0);
    end
    for (int j = 0; j < 5; j++) begin
      apply_stimulus(j <= 1, 16'd1, 16'd0, 1'b0);
      if (j >= 1) begin
        check_output($sformatf("len1 j=%0d pulse_out", j), p1, j <= 2);
        check_output($sformatf("len1 j=%0d dropped", j), d1, 0);
      end
    end
    idle(6);

    apply_stimulus(1'b1, 16'd10, 16'd0, 1'b0);
    repeat (5) apply_stimulus(1'b1, 16'd10, 16'd0, 1'b0);
    apply_stimulus(1'b0, 16'd10, 16'd0, 1'b0);
    check_output("saturated drop_count", cnt2, 3);
    apply_stimulus(1'b1, 16'd10, 16'd0, 1'b1);
    apply_stimulus(1'b0, 16'd10, 16'd0, 1'b0);
    check_output("clear-wins drop_count", cnt2, 0);
    check_output("clear-wins dropped", d2, 1);
    idle(20);

    apply_stimulus(1'b1, 16'd6, 16'd2, 1'b0);
    apply_stimulus(1'b0, 16'd6, 16'd2, 1'b0);
    apply_stimulus(1'b1, 16'd6, 16'd2, 1'b0);
    check_output("pre-reset pulse_out", p0, 1);
    #2;
    rst_n   = 1'b0;
    trigger = 1'b0;
    #1;
    check_output("async reset pulse_out", p0, 0);
    check_output("async reset busy", b0, 0);
    check_output("async reset dut1 pulse_out", p1, 0);
    model_reset();
    #1 rst_n = 1'b1;
    apply_stimulus(1'b0, 16'd5, 16'd2, 1'b0);
    check_output("reset cancels dropped", d0, 0);
    apply_stimulus(1'b1, 16'd5, 16'd2, 1'b0);
    highs = 0;
    repeat (8) begin
      apply_stimulus(1'b0, 16'd5, 16'd2, 1'b0);
      if (p0) highs++;
    end
    check_output("post-reset pulse width", highs, 5);

    repeat (600) begin
      apply_stimulus($urandom_range(0, 2) == 0, 16'($urandom_range(0, 5)),
                     16'($urandom_range(0, 4)), $urandom_range(0, 15) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
